// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode values, flag bit positions and the state
// encoding of the sequential divide/modulo unit.
package alu_pkg;

  localparam logic [5:0] ALU_ADD = 6'h00;
  localparam logic [5:0] ALU_SUB = 6'h01;
  localparam logic [5:0] ALU_AND = 6'h02;
  localparam logic [5:0] ALU_OR  = 6'h03;
  localparam logic [5:0] ALU_XOR = 6'h04;
  localparam logic [5:0] ALU_MUL = 6'h08;
  localparam logic [5:0] ALU_DIV = 6'h09;
  localparam logic [5:0] ALU_MOD = 6'h0A;
  localparam logic [5:0] ALU_SLL = 6'h0B;
  localparam logic [5:0] ALU_SRL = 6'h0C;
  localparam logic [5:0] ALU_SAR = 6'h0D;

  localparam int FLAG_CARRY    = 0;
  localparam int FLAG_ZERO     = 1;
  localparam int FLAG_NEGATIVE = 2;
  localparam int FLAG_OVERFLOW = 3;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/alu_seq_divider.sv
// Multi-cycle signed DIV/MOD unit for the ALU, restoring division with one
// quotient bit per clock.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// DIV_IDLE | waiting for start with op DIV/MOD
// DIV_CALC | r_cnt < WIDTH: one restoring step; r_cnt == WIDTH: sign-fix
//          | and register result/flags (or the divide-by-zero/overflow value)
// DIV_DONE | o_done pulse, o_busy still high, back to IDLE next edge
//
// Ports:
//   i_clk, i_rst      clock, async active-high reset
//   i_start, i_op     request strobe and opcode (0x09 DIV, 0x0A MOD)
//   i_a, i_b          signed dividend / divisor
//   i_abort           synchronous flush to IDLE, no done
//   o_busy, o_done    status; o_done is a one-cycle pulse
//   o_result          quotient or remainder, held until the next done
//   o_flags_out       {4'b0, overflow, negative, zero, carry}
module alu_seq_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [5:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic [7:0]       o_flags_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  div_state_t       r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_is_mod;
  logic             r_sign_a;
  logic             r_neg_q;
  logic             r_div0;
  logic             r_ovf;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH:0]   r_div;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic [7:0]       r_flags;

  logic             w_op_ok;
  logic             w_b_zero;
  logic             w_ovf;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH:0]   w_abs_b;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_fits;
  logic [WIDTH-1:0] w_trial;
  logic [WIDTH-1:0] w_q_sgn;
  logic [WIDTH-1:0] w_r_sgn;
  logic [WIDTH-1:0] w_fin_res;
  logic [7:0]       w_fin_flags;

  always_comb begin
    w_op_ok  = (i_op == ALU_DIV) || (i_op == ALU_MOD);
    w_b_zero = (i_b == '0);
    w_ovf    = (i_a == {1'b1, {(WIDTH-1){1'b0}}}) && (i_b == '1);
    // Read as unsigned, the W-bit negation of the most negative value is its
    // correct magnitude, so the dividend needs no extra bit.
    w_abs_a  = i_a[WIDTH-1] ? (~i_a + 1'b1) : i_a;
    w_abs_b  = i_b[WIDTH-1] ? (~{1'b1, i_b} + 1'b1) : {1'b0, i_b};

    // Partial remainder stays below |b| <= 2^(W-1), so the shifted value fits
    // in W+1 bits and the trial difference, when taken, fits in W bits.
    w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    w_fits   = (w_rem_sh >= r_div);
    w_trial  = w_rem_sh[WIDTH-1:0] - r_div[WIDTH-1:0];

    w_q_sgn  = r_neg_q  ? (~r_quo + 1'b1) : r_quo;
    w_r_sgn  = r_sign_a ? (~r_rem + 1'b1) : r_rem;

    w_fin_flags = '0;
    if (r_div0) begin
      w_fin_res                  = r_is_mod ? '0 : '1;
      w_fin_flags[FLAG_CARRY]    = 1'b1;
      w_fin_flags[FLAG_ZERO]     = r_is_mod;
      w_fin_flags[FLAG_NEGATIVE] = ~r_is_mod;
    end else if (r_ovf) begin
      w_fin_res                  = r_is_mod ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
      w_fin_flags[FLAG_ZERO]     = r_is_mod;
      w_fin_flags[FLAG_NEGATIVE] = ~r_is_mod;
      w_fin_flags[FLAG_OVERFLOW] = ~r_is_mod;
    end else begin
      w_fin_res                  = r_is_mod ? w_r_sgn : w_q_sgn;
      w_fin_flags[FLAG_ZERO]     = (w_fin_res == '0);
      w_fin_flags[FLAG_NEGATIVE] = w_fin_res[WIDTH-1];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= DIV_IDLE;
      r_cnt    <= '0;
      r_is_mod <= 1'b0;
      r_sign_a <= 1'b0;
      r_neg_q  <= 1'b0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
    end else if (i_abort) begin
      r_state <= DIV_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (i_start && w_op_ok) begin
            r_is_mod <= (i_op == ALU_MOD);
            r_sign_a <= i_a[WIDTH-1];
            r_neg_q  <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
            r_div0   <= w_b_zero;
            r_ovf    <= w_ovf;
            r_rem    <= '0;
            r_quo    <= w_abs_a;
            r_div    <= w_abs_b;
            // Special operands skip the iterations and land on the
            // finalize step at once, giving a one-edge latency to done.
            r_cnt    <= (w_b_zero || w_ovf) ? CNT_LAST : '0;
            r_busy   <= 1'b1;
            r_state  <= DIV_CALC;
          end
        end
        DIV_CALC: begin
          if (r_cnt == CNT_LAST) begin
            r_result <= w_fin_res;
            r_flags  <= w_fin_flags;
            r_done   <= 1'b1;
            r_state  <= DIV_DONE;
          end else begin
            r_rem <= w_fits ? w_trial : w_rem_sh[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], w_fits};
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DIV_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= DIV_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= DIV_IDLE;
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_result    = r_result;
  assign o_flags_out = r_flags;

endmodule

// File: tb/tb_alu_seq_divider.sv
module tb_alu_seq_divider;
  import alu_pkg::*;

  typedef struct packed {
    logic [31:0] res;
    logic [7:0]  flags;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  op = 6'h00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        abort = 1'b0;
  logic        busy, done;
  logic [31:0] result;
  logic [7:0]  flags_out;

  int n_pass = 0;
  int n_total = 0;
  int n_done = 0;
  exp_t exp_q[$];
  logic [31:0] last_res = '0;

  alu_seq_divider #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op), .i_a(a), .i_b(b),
    .i_abort(abort), .o_busy(busy), .o_done(done), .o_result(result),
    .o_flags_out(flags_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference: plain signed arithmetic with the ALU's special-case conventions.
  function automatic exp_t model(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    int sx, sy;
    sx = x; sy = y;
    if (y == 0) begin
      e.res   = (o == ALU_DIV) ? 32'hFFFF_FFFF : 32'h0;
      e.flags = (o == ALU_DIV) ? 8'h05 : 8'h03;
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      e.res   = (o == ALU_DIV) ? 32'h8000_0000 : 32'h0;
      e.flags = (o == ALU_DIV) ? 8'h0C : 8'h02;
    end else begin
      e.res   = (o == ALU_DIV) ? 32'(sx / sy) : 32'(sx % sy);
      e.flags = {5'b0, e.res[31], (e.res == 0), 1'b0};
    end
    return e;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT signals done.
  always @(posedge clk) begin
    #1;
    if (done) begin
      exp_t e;
      n_done++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: got result %h with no request pending at %0t", result, $time);
      end else begin
        e = exp_q.pop_front();
        chk("result", result, e.res);
        chk("flags", {24'b0, flags_out}, {24'b0, e.flags});
        last_res = e.res;
      end
    end
  end

  task automatic run_op(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y);
    int n;
    int lat;
    exp_t e;
    e = model(o, x, y);
    lat = (y == 0 || (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) ? 1 : 33;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", {31'b0, busy}, 32'd1);
    n = 0;
    while (!done && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) begin
      n_total++;
      $display("FAIL done_timeout: got no done after %0d edges, required %0d", n, lat);
    end else begin
      chk("latency", n, lat);
      chk("busy_with_done", {31'b0, busy}, 32'd1);
      @(posedge clk); #1;
      chk("done_pulse_width", {31'b0, done}, 32'd0);
      chk("busy_after_done", {31'b0, busy}, 32'd0);
    end
  endtask

  initial begin
    int d0;
    logic [31:0] ra, rb;
    #12;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_flags", {24'b0, flags_out}, 32'd0);
    @(negedge clk); rst = 1'b0;

    run_op(ALU_DIV, 32'd42, 32'd6);
    run_op(ALU_DIV, -32'sd10, 32'd2);
    run_op(ALU_MOD, -32'sd7, 32'd2);
    run_op(ALU_MOD, 32'd43, 32'd6);
    run_op(ALU_DIV, 32'd42, 32'd0);
    run_op(ALU_MOD, 32'd43, 32'd0);
    run_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(ALU_MOD, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(ALU_DIV, 32'h8000_0000, 32'd1);
    run_op(ALU_MOD, 32'h7FFF_FFFF, 32'h8000_0000);

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1, 2: rb = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(1, 20)) : -32'($urandom_range(1, 20));
        3: if ($urandom_range(0, 1) != 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        default: ;
      endcase
      run_op(($urandom_range(0, 1) != 0) ? ALU_DIV : ALU_MOD, ra, rb);
    end

    // Start during CALC must be ignored.
    d0 = n_done;
    exp_q.push_back(model(ALU_DIV, 32'd42, 32'd6));
    @(negedge clk); start = 1'b1; op = ALU_DIV; a = 32'd42; b = 32'd6;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; a = 32'd100; b = 32'd10;
    @(negedge clk); start = 1'b0;
    repeat (80) @(negedge clk);
    chk("busy_start_single_done", n_done - d0, 32'd1);
    chk("busy_start_result", result, 32'd7);

    // Unsupported opcode.
    d0 = n_done;
    @(negedge clk); start = 1'b1; op = 6'h00; a = 32'd42; b = 32'd6;
    @(negedge clk); start = 1'b0;
    chk("badop_busy", {31'b0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    chk("badop_no_done", n_done - d0, 32'd0);

    // Abort together with start in IDLE.
    @(negedge clk); start = 1'b1; abort = 1'b1; op = ALU_DIV; a = 32'd9; b = 32'd3;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", {31'b0, busy}, 32'd0);

    // Abort mid-operation.
    d0 = n_done;
    @(negedge clk); start = 1'b1; op = ALU_DIV; a = 32'd42; b = 32'd6;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    @(negedge clk); abort = 1'b0;
    repeat (45) @(negedge clk);
    chk("abort_no_done", n_done - d0, 32'd0);
    chk("abort_result_held", result, last_res);

    // Asynchronous reset mid-CALC.
    d0 = n_done;
    @(negedge clk); start = 1'b1; op = ALU_MOD; a = 32'd43; b = 32'd6;
    @(negedge clk); start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("rst_no_done", n_done - d0, 32'd0);
    run_op(ALU_DIV, 32'd42, 32'd6);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
